count_snapshot_fifo: RTL and testbench
======================================

# count_snapshot_fifo

Downstream consumer of the wishbone-programmable counter's `count` bus. It samples the counter value at a programmable period and pushes each sample into a DEPTH-entry FIFO. Firmware drains the FIFO over the Wishbone slave port. The block raises an interrupt when the FIFO level reaches a programmable threshold, so firmware can log count history without polling every cycle.

## Interface
- `BITS`, 30: width of the sampled count and of the stored FIFO entries.
- `DEPTH`, 8: number of FIFO entries; must be a power of two, 2..16.
- `wb_clk_i`  input  1  single clock; all state on rising edge.
- `wb_rst_i`  input  1  reset, asynchronous, active-high.
- `wbs_stb_i`  input  1  Wishbone strobe.
- `wbs_cyc_i`  input  1  Wishbone cycle.
- `wbs_we_i`  input  1  write enable.
- `wbs_sel_i`  input  4  byte-lane select for writes.
- `wbs_dat_i`  input  32  write data.
- `wbs_adr_i`  input  32  address; only bits [3:2] are decoded.
- `wbs_ack_o`  output  1  one-cycle acknowledge.
- `wbs_dat_o`  output  32  read data, valid with ack.
- `count`  input  BITS  counter value being sampled.
- `irq`  output  1  level interrupt.

## Operation
Definitions:
- valid = `wbs_cyc_i` & `wbs_stb_i`.
- Writes honour `wbs_sel_i` byte lanes.
- Unused read bits return 0.

Register map (`wbs_adr_i`[3:2]):
- 0 CTRL (RW):
  - bit0 EN: sampling enable.
  - bit1 CLR: write-1 pulse, reads 0. Flushes the FIFO, clears OVF and reloads the timer.
  - bits[7:4] THRESH: irq threshold.
- 1 PERIOD (RW), bits[15:0]: a sample is taken every PERIOD+1 cycles.
- 2 STATUS:
  - bits[4:0] LEVEL (RO).
  - bit8 EMPTY (RO).
  - bit9 FULL (RO).
  - bit10 OVF (sticky; write 1 clears).
- 3 DATA (RO): a read returns the FIFO head in bits[BITS-1:0] and pops it.

Sample timer (down-counter, 16 bits):
- When EN=0, the timer is held at PERIOD.
- When EN=1, the timer decrements each cycle.
- When the timer is 0: a capture fires, `count` is latched that cycle, and the timer reloads PERIOD.
- A PERIOD write or a CLR reloads the timer on the write-ack cycle.
- PERIOD=0 gives a capture on every cycle while EN=1.

FIFO:
- Circular buffer with log2(DEPTH)-bit read and write pointers plus a LEVEL counter (0..DEPTH). Pointers wrap modulo DEPTH.
- Capture while not full: push, LEVEL+1.
- Capture while full: the sample is dropped and OVF is set.
  - Exception: if a pop happens on the same cycle, the pop is evaluated first, the push succeeds and LEVEL is unchanged.
- DATA read while empty: returns 0, no pop, no error flag.
- Pop and push on the same cycle with the FIFO empty: the read returns 0 and the push is stored (LEVEL=1).
- CLR on the same cycle as a capture: CLR wins; the FIFO ends empty and OVF=0.

Interrupt:
- `irq` = (THRESH != 0) & (LEVEL >= THRESH), registered.
- THRESH > DEPTH never fires.

## Timing
Reset values:
- `wbs_ack_o`=0, `wbs_dat_o`=0, `irq`=0.
- EN=0, THRESH=0, PERIOD=16'hFFFF, timer=16'hFFFF.
- LEVEL=0, pointers=0, OVF=0. FIFO storage is not reset.

Wishbone handshake:
- `wbs_ack_o` rises on the edge after valid is seen with ack low. It is high for exactly one cycle, then low for at least one cycle, even if valid is held.
- `wbs_dat_o` is registered and updates on the same edge as ack. It holds its value otherwise.

Register update timing:
- Register writes take effect on the ack edge.
- A DATA pop occurs on the ack edge. LEVEL/EMPTY/FULL reflect the pop on the following cycle.
- A captured sample is visible in LEVEL on the cycle after the capture edge. It is readable by a DATA access whose ack edge is at or after that cycle.

`irq` latency:
- Rises 1 cycle after LEVEL reaches THRESH.
- Falls 1 cycle after LEVEL drops below THRESH, or after a THRESH write.

Reset mid-operation:
- Asserting `wb_rst_i` during an access immediately forces ack=0 and restores all reset values.
- No ack is produced for the interrupted access.

## Test plan
- Reset with `count`=30'h1234 applied -> ack=0, irq=0. STATUS read returns 0x100 (EMPTY). PERIOD reads 0xFFFF. DATA read returns 0.
- PERIOD=3, EN=1, `count` incrementing by 1 per cycle -> captures occur every 4 cycles. Successive DATA reads differ by exactly 4.
- PERIOD=0, EN=1, DEPTH=8, no reads for 12 cycles:
  - LEVEL=8, FULL=1, OVF=1.
  - Eight DATA reads return the first 8 captured values in order; a ninth read returns 0 with EMPTY=1.
  - Writing STATUS=0x400 clears OVF.
- THRESH=4, PERIOD=1 -> irq rises 1 cycle after LEVEL=4. One DATA read drops LEVEL to 3 and irq falls 1 cycle later.
- FIFO full, with a capture and a DATA-read ack on the same edge -> LEVEL stays 8, OVF stays 0, and the head value is returned.
- `wb_rst_i` pulsed while a read strobe is held with LEVEL=5 -> no ack during reset. After release: LEVEL=0, EN=0, and the held strobe gets an ack on the second cycle after release.

Source files
------------

// File: rtl/count_snapshot_fifo.sv
// Periodic sampler of a counter bus into a DEPTH-entry FIFO, drained over a
// Wishbone slave port, with a level-threshold interrupt.
module count_snapshot_fifo #(
  parameter int BITS  = 30,
  parameter int DEPTH = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_dat_i,
  input  logic [31:0]     wbs_adr_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [BITS-1:0] count,
  output logic            irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic            en, ovf;
  logic [3:0]      thresh;
  logic [15:0]     period, timer, period_nxt;
  logic [AW-1:0]   wptr, rptr;
  logic [LW-1:0]   level;
  logic [BITS-1:0] mem [DEPTH];
  logic [1:0]      adr;
  logic            acc, wr, capture, empty, full, pop, push, clr, period_wr, ovf_set, ovf_clr;
  logic [31:0]     rdata;
  logic            unused_bits;

  assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_dat_i[3:2], wbs_sel_i[3:2]};

  // A new access is accepted only while ack is low, giving ack/idle alternation.
  assign acc       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr        = acc & wbs_we_i;
  assign adr       = wbs_adr_i[3:2];
  assign capture   = en & (timer == 16'd0);
  assign empty     = (level == '0);
  assign full      = (level == LW'(DEPTH));
  assign pop       = acc & ~wbs_we_i & (adr == 2'd3) & ~empty;
  assign push      = capture & (~full | pop);
  assign ovf_set   = capture & full & ~pop;
  assign clr       = wr & (adr == 2'd0) & wbs_sel_i[0] & wbs_dat_i[1];
  assign ovf_clr   = wr & (adr == 2'd2) & wbs_sel_i[1] & wbs_dat_i[10];
  assign period_wr = wr & (adr == 2'd1);
  assign period_nxt = {wbs_sel_i[1] ? wbs_dat_i[15:8] : period[15:8],
                       wbs_sel_i[0] ? wbs_dat_i[7:0]  : period[7:0]};

  always_comb begin
    rdata = '0;
    case (adr)
      2'd0: rdata = {24'd0, thresh, 3'd0, en};
      2'd1: rdata = {16'd0, period};
      2'd2: rdata = {21'd0, ovf, full, empty, 3'd0, 5'(level)};
      default: rdata = empty ? 32'd0 : 32'(mem[rptr]);
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= acc;
      if (acc) wbs_dat_o <= rdata;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      en     <= 1'b0;
      thresh <= '0;
      period <= 16'hFFFF;
    end else begin
      if (wr && adr == 2'd0 && wbs_sel_i[0]) begin
        en     <= wbs_dat_i[0];
        thresh <= wbs_dat_i[7:4];
      end
      if (period_wr) period <= period_nxt;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)            timer <= 16'hFFFF;
    else if (period_wr)      timer <= period_nxt;
    else if (clr || !en)     timer <= period;
    else if (capture)        timer <= period;
    else                     timer <= timer - 16'd1;
  end

  // CLR overrides any same-cycle capture: FIFO ends empty with OVF clear.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      ovf   <= 1'b0;
    end else begin
      if (pop)  rptr <= rptr + AW'(1);
      if (push) wptr <= wptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
      ovf <= (ovf & ~ovf_clr) | ovf_set;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wptr] <= count;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) irq <= 1'b0;
    else          irq <= (thresh != 4'd0) && (5'(level) >= {1'b0, thresh});
  end
endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Bench for count_snapshot_fifo: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_count_snapshot_fifo;
  localparam int BITS = 30, DEPTH = 8;

  logic clk = 0, rst = 1, stb = 0, cyc = 0, we = 0;
  logic [3:0] sel = 0;
  logic [31:0] dat_i = 0, adr = 0, dat_o;
  logic [BITS-1:0] count = 0;
  logic ack, irq;
  bit rand_count = 0;
  int checks = 0, failures = 0;

  count_snapshot_fifo #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
    .wbs_ack_o(ack), .wbs_dat_o(dat_o), .count(count), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue, sampling as "cycles since reload".
  logic [BITS-1:0] q[$];
  bit m_en, m_ack, m_irq, m_ovf;
  int m_thresh, m_period, m_age;
  logic [31:0] m_dat;

  task automatic model_reset();
    q.delete();
    m_en = 0; m_ack = 0; m_irq = 0; m_ovf = 0;
    m_thresh = 0; m_period = 16'hFFFF; m_age = 0; m_dat = 0;
  endtask

  task automatic model_step();
    bit acc, cap, clr, ovf_set, ovf_clr, nirq;
    logic [31:0] rd;
    int a;
    if (rst) begin model_reset(); return; end
    a = int'(adr[3:2]);
    acc = cyc && stb && !m_ack;
    cap = m_en && (m_age == m_period);
    nirq = (m_thresh != 0) && (q.size() >= m_thresh);
    rd = 0;
    case (a)
      0: rd = m_thresh * 16 + (m_en ? 1 : 0);
      1: rd = m_period;
      2: rd = q.size() + (q.size() == 0 ? 256 : 0) + (q.size() == DEPTH ? 512 : 0) + (m_ovf ? 1024 : 0);
      default: rd = (q.size() > 0) ? 32'(q[0]) : 0;
    endcase
    if (acc && !we && a == 3 && q.size() > 0) void'(q.pop_front());
    ovf_set = 0;
    if (cap) begin
      if (q.size() < DEPTH) q.push_back(count);
      else ovf_set = 1;
    end
    if (!m_en || cap) m_age = 0; else m_age++;
    clr = 0; ovf_clr = 0;
    if (acc && we) begin
      if (a == 0 && sel[0]) begin
        m_en = dat_i[0]; m_thresh = int'(dat_i[7:4]); clr = dat_i[1];
      end
      if (a == 1) begin
        if (sel[0]) m_period = (m_period & 32'hFF00) | int'(dat_i[7:0]);
        if (sel[1]) m_period = (m_period & 32'h00FF) | (int'(dat_i[15:8]) << 8);
        m_age = 0;
      end
      if (a == 2 && sel[1] && dat_i[10]) ovf_clr = 1;
    end
    if (clr) begin q.delete(); m_age = 0; end
    m_ovf = clr ? 0 : ((m_ovf && !ovf_clr) || ovf_set);
    m_irq = nirq;
    m_ack = acc;
    if (acc) m_dat = rd;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    chk("ack_vs_model", {31'd0, ack}, {31'd0, m_ack});
    chk("dat_vs_model", dat_o, m_dat);
    chk("irq_vs_model", {31'd0, irq}, {31'd0, m_irq});
  end

  initial forever begin
    @(negedge clk);
    count = rand_count ? BITS'($urandom) : count + 1'b1;
  end

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    cyc = 1; stb = 1; we = 1; adr = {28'd0, a, 2'b00}; sel = s; dat_i = d;
    do begin @(negedge clk); n++; end while (!ack && n < 20);
    chk("write_ack", {31'd0, ack}, 32'd1);
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    int n = 0;
    cyc = 1; stb = 1; we = 0; adr = {28'd0, a, 2'b00}; sel = 4'hF;
    do begin @(negedge clk); n++; end while (!ack && n < 20);
    chk("read_ack", {31'd0, ack}, 32'd1);
    d = dat_o;
    cyc = 0; stb = 0;
  endtask

  initial begin
    logic [31:0] d, d0, h0, h1;
    int lvl, n;
    repeat (3) @(negedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_ack", {31'd0, ack}, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    wb_read(2'd2, d); chk("reset_status", d, 32'h100);
    wb_read(2'd1, d); chk("reset_period", d, 32'hFFFF);
    wb_read(2'd3, d); chk("reset_data_empty", d, 32'd0);

    // Period 3: samples every 4 cycles of an incrementing count.
    wb_write(2'd1, 32'd3, 4'hF);
    wb_write(2'd0, 32'd1, 4'h1);
    repeat (10) @(negedge clk);
    wb_read(2'd3, d0); wb_read(2'd3, d);
    chk("period3_delta", d - d0, 32'd4);
    wb_write(2'd0, 32'h2, 4'h1);

    // Period 0: overflow after 8 samples, ordered drain, OVF clear.
    wb_write(2'd1, 32'd0, 4'hF);
    wb_write(2'd0, 32'd1, 4'h1);
    repeat (12) @(negedge clk);
    wb_write(2'd0, 32'd0, 4'h1);
    wb_read(2'd2, d); chk("full_ovf_status", d, 32'h608);
    d0 = 0;
    for (int i = 0; i < 8; i++) begin
      wb_read(2'd3, d);
      if (i == 0) d0 = d; else chk("drain_order", d, d0 + 32'(i));
    end
    wb_read(2'd3, d); chk("drain_ninth_zero", d, 32'd0);
    wb_read(2'd2, d); chk("empty_ovf_status", d, 32'h500);
    wb_write(2'd2, 32'h400, 4'h2);
    wb_read(2'd2, d); chk("ovf_cleared", d, 32'h100);

    // Threshold 4 interrupt rise and fall.
    wb_write(2'd1, 32'd1, 4'hF);
    wb_write(2'd0, 32'h41, 4'h1);
    n = 0;
    while (!irq && n < 40) begin @(negedge clk); n++; end
    chk("irq_rise", {31'd0, irq}, 32'd1);
    wb_write(2'd0, 32'h40, 4'h1);
    wb_read(2'd2, d); lvl = int'(d[4:0]);
    chk("irq_level_4_or_5", {31'd0, (lvl == 4 || lvl == 5)}, 32'd1);
    for (int i = 0; i < lvl - 3; i++) wb_read(2'd3, d);
    chk("irq_held_at_pop", {31'd0, irq}, 32'd1);
    @(negedge clk);
    chk("irq_fall", {31'd0, irq}, 32'd0);
    wb_read(2'd2, d); chk("level_3", d, 32'h003);

    // Full FIFO with capture and DATA pop on the same edge.
    wb_write(2'd0, 32'h2, 4'h1);
    wb_write(2'd1, 32'd2, 4'hF);
    wb_write(2'd0, 32'd1, 4'h1);
    repeat (26) @(negedge clk);
    wb_read(2'd3, h0);
    wb_write(2'd0, 32'd0, 4'h1);
    wb_read(2'd2, d); chk("pushpop_full_status", d, 32'h208);
    wb_read(2'd3, h1); chk("pushpop_head_delta", h1 - h0, 32'd3);

    // Reset during a held read with LEVEL=5.
    wb_write(2'd0, 32'h2, 4'h1);
    wb_write(2'd1, 32'd0, 4'hF);
    wb_write(2'd0, 32'd1, 4'h1);
    repeat (4) @(negedge clk);
    wb_write(2'd0, 32'd0, 4'h1);
    wb_read(2'd2, d); chk("level_5", d, 32'h005);
    #1;
    cyc = 1; stb = 1; we = 0; adr = 32'hC; rst = 1;
    repeat (2) begin @(negedge clk); chk("ack_in_reset", {31'd0, ack}, 32'd0); end
    #1 rst = 0;
    @(negedge clk);
    chk("ack_after_release", {31'd0, ack}, 32'd1);
    chk("data_after_release", dat_o, 32'd0);
    cyc = 0; stb = 0;
    wb_read(2'd2, d); chk("status_after_reset", d, 32'h100);
    wb_read(2'd0, d); chk("ctrl_after_reset", d, 32'd0);

    // Random traffic against the model.
    rand_count = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      cyc = ($urandom_range(0, 3) != 0);
      stb = ($urandom_range(0, 3) != 0);
      we = 1'($urandom_range(0, 1));
      adr = $urandom; sel = 4'($urandom); dat_i = $urandom;
      if (adr[3:2] == 2'd1) dat_i[15:0] = 16'($urandom_range(0, 5));
      if (adr[3:2] == 2'd0) begin
        dat_i[1] = ($urandom_range(0, 15) == 0);
        dat_i[0] = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk); #1;
    cyc = 0; stb = 0; rst = 0;
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
